// File: rtl/float_add_sched.sv
// Round-robin arbiter that shares one non-pipelined float adder among NREQ clients.
// It runs one operation at a time, with a result timeout and a held response channel.
module float_add_sched #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [NREQ-1:0]      ReqValid,
    output logic [NREQ-1:0]      ReqReady,
    input  logic [NREQ*32-1:0]   ReqOp1,
    input  logic [NREQ*32-1:0]   ReqOp2,
    output logic [NREQ-1:0]      RespValid,
    input  logic [NREQ-1:0]      RespReady,
    output logic [31:0]          RespResult,
    output logic                 RespError,
    output logic [31:0]          AddOp1,
    output logic [31:0]          AddOp2,
    output logic                 AddInputValid,
    input  logic [31:0]          AddResult,
    input  logic                 AddResultValid,
    output logic                 Busy,
    output logic                 StrayResult
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = 10;
    localparam logic [GW:0]   NREQ_W  = (GW+1)'(NREQ);
    localparam logic [TW-1:0] TMO_END = TW'(TIMEOUT - 1);
    localparam logic [31:0]   QNAN    = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_reg, state_next;
    logic [GW-1:0]   grant_reg;
    logic [GW-1:0]   last_grant_reg;
    logic [TW-1:0]   timer_reg;
    logic            arv_prev_reg;
    logic [31:0]     op1_reg, op2_reg;
    logic            add_valid_reg;
    logic [31:0]     result_reg;
    logic            error_reg;
    logic            stray_reg;

    logic [GW-1:0]   cand [NREQ];
    logic [NREQ-1:0] hit;
    logic [GW-1:0]   win_idx;
    logic            grant_found;
    logic            result_rise;
    logic            timer_done;

    // Candidate gi is the requester gi+1 places after the last grant, wrapped.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
            logic [GW:0] sum_w;
            assign sum_w     = {1'b0, last_grant_reg} + (GW+1)'(gi + 1);
            assign cand[gi]  = (sum_w >= NREQ_W) ? GW'(sum_w - NREQ_W) : sum_w[GW-1:0];
            assign hit[gi]   = ReqValid[cand[gi]];
        end
    endgenerate

    always_comb begin
        win_idx     = cand[0];
        grant_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && hit[k]) begin
                grant_found = 1'b1;
                win_idx     = cand[k];
            end
        end
    end

    assign result_rise = AddResultValid & ~arv_prev_reg;
    assign timer_done  = (timer_reg == TMO_END);

    always_comb begin
        state_next = state_reg;
        ReqReady   = '0;
        RespValid  = '0;
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    ReqReady[win_idx] = 1'b1;
                    state_next        = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (result_rise || timer_done) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                RespValid[grant_reg] = 1'b1;
                if (RespReady[grant_reg]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= GW'(NREQ - 1);
            timer_reg      <= '0;
            arv_prev_reg   <= 1'b0;
            op1_reg        <= '0;
            op2_reg        <= '0;
            add_valid_reg  <= 1'b0;
            result_reg     <= '0;
            error_reg      <= 1'b0;
            stray_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            arv_prev_reg  <= AddResultValid;
            add_valid_reg <= (state_reg == IDLE) && grant_found;

            if (state_reg == IDLE && grant_found) begin
                grant_reg <= win_idx;
                op1_reg   <= ReqOp1[32*win_idx +: 32];
                op2_reg   <= ReqOp2[32*win_idx +: 32];
            end

            if (state_reg == ISSUE) begin
                timer_reg <= '0;
            end else if (state_reg == WAIT) begin
                timer_reg <= timer_reg + 1'b1;
            end

            // A genuine result beats a simultaneous timeout.
            if (state_reg == WAIT && result_rise) begin
                result_reg <= AddResult;
                error_reg  <= 1'b0;
            end else if (state_reg == WAIT && timer_done) begin
                result_reg <= QNAN;
                error_reg  <= 1'b1;
            end

            if (state_reg == RESP && RespReady[grant_reg]) begin
                last_grant_reg <= grant_reg;
            end

            if (result_rise && state_reg != WAIT) begin
                stray_reg <= 1'b1;
            end
        end
    end

    assign AddOp1        = op1_reg;
    assign AddOp2        = op2_reg;
    assign AddInputValid = add_valid_reg;
    assign RespResult    = result_reg;
    assign RespError     = error_reg;
    assign Busy          = (state_reg != IDLE);
    assign StrayResult   = stray_reg;

endmodule
